// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy (pending producer) scoreboard.
// Two write ports (port 1 wins on address collision), RD_PORTS combinational
// read ports, issue/flush control of busy bits and a registered busy count.
// Optional macro REGFILE_BYPASS_EN: reads see same-cycle write data and busy.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr_i,
  output logic [RD_PORTS*DATA_W-1:0] rd_data_o,
  output logic [RD_PORTS-1:0]        rd_busy_o,
  input  logic                       wr0_en_i,
  input  logic [ADDR_W-1:0]          wr0_addr_i,
  input  logic [DATA_W-1:0]          wr0_data_i,
  input  logic                       wr1_en_i,
  input  logic [ADDR_W-1:0]          wr1_addr_i,
  input  logic [DATA_W-1:0]          wr1_data_i,
  input  logic                       iss_en_i,
  input  logic [ADDR_W-1:0]          iss_rd_i,
  input  logic                       flush_i,
  output logic [ADDR_W:0]            busy_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr0_hit, wr1_hit, iss_set;

  // Qualified write/issue strobes; address 0 is hardwired and never touched.
  always_comb begin
    wr0_hit = wr0_en_i && (wr0_addr_i != '0);
    wr1_hit = wr1_en_i && (wr1_addr_i != '0);
    iss_set = iss_en_i && (iss_rd_i != '0) && !flush_i;
  end

  // Next busy vector: clears from writes, then flush or issue set (set wins).
  always_comb begin
    busy_d = busy_q;
    if (wr0_hit) busy_d[wr0_addr_i] = 1'b0;
    if (wr1_hit) busy_d[wr1_addr_i] = 1'b0;
    if (flush_i) busy_d = '0;
    else if (iss_set) busy_d[iss_rd_i] = 1'b1;
  end

  // Population count of the next busy vector, registered into busy_cnt_o.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  // Data storage; port 1 assignment comes last so it wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_hit) mem_q[wr0_addr_i] <= wr0_data_i;
      if (wr1_hit) mem_q[wr1_addr_i] <= wr1_data_i;
    end
  end

  // Busy bits and busy count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdat;
  logic              rbusy;

  // Combinational read ports, forced to zero while reset is asserted.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
    rdat      = '0;
    rbusy     = 1'b0;
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      ra    = rd_addr_i[k*ADDR_W +: ADDR_W];
      rdat  = mem_q[ra];
      rbusy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr1_hit && (wr1_addr_i == ra)) begin
        rdat  = wr1_data_i;
        rbusy = iss_set && (iss_rd_i == ra);
      end else if (wr0_hit && (wr0_addr_i == ra)) begin
        rdat  = wr0_data_i;
        rbusy = iss_set && (iss_rd_i == ra);
      end
`endif
      if (rst_n) begin
        rd_data_o[k*DATA_W +: DATA_W] = rdat;
        rd_busy_o[k]                  = rbusy;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (DATA_W=32, ADDR_W=5, RD_PORTS=2).
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, iss_en, flush;
  logic [4:0]  wr0_addr, wr1_addr, iss_rd;
  logic [31:0] wr0_data, wr1_data;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr0_en_i   (wr0_en),
    .wr0_addr_i (wr0_addr),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_addr_i (wr1_addr),
    .wr1_data_i (wr1_data),
    .iss_en_i   (iss_en),
    .iss_rd_i   (iss_rd),
    .flush_i    (flush),
    .busy_cnt_o (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    iss_en = 0; iss_rd = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    idle();
    rd_addr = {5'd5, 5'd5};
    rst_n = 0;
    #12;
    check("rst_data", rd_data, 64'h0);
    check("rst_busy", {62'h0, rd_busy}, 64'h0);
    check("rst_cnt", {58'h0, busy_cnt}, 64'h0);
    @(negedge clk);
    rst_n = 1;

    // x5 = DEADBEEF via port 0, read on both ports
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    tick(); idle();
    rd(5, 5);
    check("x5_data", rd_data, 64'hDEADBEEF_DEADBEEF);
    check("x5_busy", {62'h0, rd_busy}, 64'h0);

    // collision on x7: port 1 wins
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
    tick(); idle();
    rd(7, 5);
    check("x7_prio", rd_data, {32'hDEADBEEF, 32'h22});

    // issue x3, then write x3 on port 1 plus re-issue: stays busy
    iss_en = 1; iss_rd = 3;
    tick(); idle();
    rd(3, 0);
    check("x3_busy1", {62'h0, rd_busy}, 64'h1);
    check("x3_cnt1", {58'h0, busy_cnt}, 64'd1);
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h33;
    iss_en = 1; iss_rd = 3;
    tick(); idle();
    rd(3, 3);
    check("x3_setwin", {62'h0, rd_busy}, 64'h3);
    check("x3_cnt2", {58'h0, busy_cnt}, 64'd1);
    check("x3_data", rd_data, {32'h33, 32'h33});
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h44;
    tick(); idle();
    rd(3, 0);
    check("x3_clear", {62'h0, rd_busy}, 64'h0);
    check("x3_cnt0", {58'h0, busy_cnt}, 64'd0);
    // write to non-busy register: no underflow
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h55;
    tick(); idle();
    check("nobusy_cnt", {58'h0, busy_cnt}, 64'd0);

    // issue x1,x2,x4 then flush with issue x9 and a write to x10
    iss_en = 1; iss_rd = 1; tick();
    iss_rd = 2; tick();
    iss_rd = 4; tick(); idle();
    rd(1, 4);
    check("pre_flush_cnt", {58'h0, busy_cnt}, 64'd3);
    check("pre_flush_busy", {62'h0, rd_busy}, 64'h3);
    flush = 1; iss_en = 1; iss_rd = 9;
    wr0_en = 1; wr0_addr = 10; wr0_data = 32'hAB;
    tick(); idle();
    check("flush_cnt", {58'h0, busy_cnt}, 64'd0);
    rd(9, 2);
    check("flush_busy_a", {62'h0, rd_busy}, 64'h0);
    rd(4, 1);
    check("flush_busy_b", {62'h0, rd_busy}, 64'h0);
    rd(10, 0);
    check("flush_wr", rd_data, {32'h0, 32'hAB});

    // same-cycle read of x8 while it is written
    wr0_en = 1; wr0_addr = 8; wr0_data = 32'h5A;
    rd(8, 0);
`ifdef REGFILE_BYPASS_EN
    check("x8_same", rd_data, {32'h0, 32'h5A});
`else
    check("x8_same", rd_data, 64'h0);
`endif
    check("x8_same_busy", {62'h0, rd_busy}, 64'h0);
    tick(); idle();
    rd(8, 0);
    check("x8_next", rd_data, {32'h0, 32'h5A});

    // x0 is immune to writes and issues
    iss_en = 1; iss_rd = 6;
    tick(); idle();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFF;
    iss_en = 1; iss_rd = 0;
    tick(); idle();
    rd(0, 6);
    check("x0_data", rd_data[31:0], 64'h0);
    check("x0_busy", {62'h0, rd_busy}, 64'h2);
    check("x0_cnt", {58'h0, busy_cnt}, 64'd1);

    // reset asserted mid-sequence with a write pending
    wr0_en = 1; wr0_addr = 11; wr0_data = 32'h1234;
    iss_en = 1; iss_rd = 12;
    rd(5, 6);
    #1;
    rst_n = 0;
    #1;
    check("midrst_data", rd_data, 64'h0);
    check("midrst_busy", {62'h0, rd_busy}, 64'h0);
    check("midrst_cnt", {58'h0, busy_cnt}, 64'd0);
    tick();
    check("inrst_cnt", {58'h0, busy_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    idle();
    tick();
    rd(5, 11);
    check("postrst_data", rd_data, 64'h0);
    rd(12, 6);
    check("postrst_busy", {62'h0, rd_busy}, 64'h0);
    wr1_en = 1; wr1_addr = 12; wr1_data = 32'hCAFE;
    tick(); idle();
    rd(12, 0);
    check("postrst_wr", rd_data, {32'h0, 32'hCAFE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter RD_PORTS, default 2, legal range 1..4, meaning number of independent read ports.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-006 SHALL have port rd_addr_i, input, RD_PORTS*ADDR_W, packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data_o, output, RD_PORTS*DATA_W, packed read data, same packing as rd_addr_i.
REQ-008 SHALL have port rd_busy_o, output, RD_PORTS, per read port: the addressed register has a pending producer.
REQ-009 SHALL have ports wr0_en_i (1), wr0_addr_i (ADDR_W) and wr0_data_i (DATA_W), inputs, forming write port 0.
REQ-010 SHALL have ports wr1_en_i (1), wr1_addr_i (ADDR_W) and wr1_data_i (DATA_W), inputs, forming write port 1.
REQ-011 SHALL have ports iss_en_i (1) and iss_rd_i (ADDR_W), inputs: an issued instruction will write iss_rd_i.
REQ-012 SHALL have port flush_i, input, 1: clear all busy bits.
REQ-013 SHALL have port busy_cnt_o, output, ADDR_W+1: number of registers currently marked busy.

Function
REQ-014 SHALL hold 2**ADDR_W registers of DATA_W bits, each with one busy bit.
REQ-015 SHALL make reads combinational, with zero-cycle latency from rd_addr_i to rd_data_o and rd_busy_o.
REQ-016 SHALL read address 0 as data 0 and busy 0; writes and issues to address 0 have no effect.
REQ-017 SHALL write wrN_data_i to register wrN_addr_i on the rising edge when wrN_en_i=1 and wrN_addr_i!=0.
REQ-018 SHALL, when both write ports target the same nonzero address in one cycle, store wr1_data_i (port 1 has priority).
REQ-019 SHALL clear the busy bit of each register written by either write port.
REQ-020 SHALL set the busy bit of iss_rd_i when iss_en_i=1 and iss_rd_i!=0.
REQ-021 SHALL give set priority when a set and a clear hit the same register in one cycle, so the register ends busy (a newer producer is pending).
REQ-022 SHALL, on flush_i=1, clear every busy bit and ignore that cycle's iss_en_i; writes in that cycle still update data.
REQ-023 SHALL update busy_cnt_o as a registered population count equal to the busy bits after each edge, with range 0..2**ADDR_W-1.
REQ-024 SHALL ignore a write to a non-busy register for busy purposes, with no error and no underflow.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously set all registers to 0, all busy bits to 0 and busy_cnt_o to 0.
REQ-026 SHALL force rd_data_o and rd_busy_o to 0 while rst_n=0.
REQ-027 SHALL discard writes and issues present during reset, including a reset asserted mid-operation, and resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL support macro REGFILE_BYPASS_EN.
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, return same-cycle write data on a read of an address written this cycle (port 1 data if both ports write it) and drive rd_busy_o=0 unless iss_en_i sets that address this cycle.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return the stored value and stored busy bit on every read; a same-cycle write is visible on the next cycle.

Verification
REQ-031 SHALL cover: reset, write x5=0xDEADBEEF via port 0, then read x5 on all ports -> 0xDEADBEEF, busy 0.
REQ-032 SHALL cover: both ports write x7 in one cycle (0x11 on port 0, 0x22 on port 1) -> x7 reads 0x22.
REQ-033 SHALL cover: issue x3, then next cycle port-1 write x3 together with a new issue of x3 -> x3 busy=1 and busy_cnt_o=1.
REQ-034 SHALL cover: issue x1, x2 and x4 on consecutive cycles, then flush_i with issue x9 in the same cycle -> all busy 0 and busy_cnt_o=0.
REQ-035 SHALL cover: with the macro, write x8=0x5A and read x8 in the same cycle -> 0x5A, busy 0; without the macro -> old value 0.
REQ-036 SHALL cover: write x0=0xFFFF and issue x0 -> x0 reads 0, busy 0, busy_cnt_o unchanged; then assert rst_n mid-sequence -> all reads 0 immediately.
